// File: rtl/mem_unit_if.sv
// ---------------------------------------------------------------------------
// mem_unit_if -- bus bundle between the control unit / program loader and
// mem_unit.
//
// Optional feature macro: MEM_MMIO_OUT_EN (adds mmio_out / mmio_strobe).
//
// Signals:
//   addressbus, read, write, toram    CPU address, read/write requests, write data
//   fromram                           read data returned to the CPU
//   cpu_enable                        enable for the control unit
//   ld_valid, ld_data, ld_last        loader word handshake (valid side)
//   ld_ready                          loader word handshake (ready side)
//   ld_start                          single-cycle (re)load request
//   load_err                          sticky load-overflow flag
//   state_o                           FSM state for debug
//   mmio_out, mmio_strobe             memory-mapped output port (optional)
//
// Modports: master = CPU/loader side, slave = mem_unit.
// ---------------------------------------------------------------------------
interface mem_unit_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
) ();
   logic [ADDR_W-1:0] addressbus;
   logic              read;
   logic              write;
   logic [DATA_W-1:0] toram;
   logic [DATA_W-1:0] fromram;
   logic              cpu_enable;
   logic              ld_valid;
   logic              ld_ready;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              ld_start;
   logic              load_err;
   logic [1:0]        state_o;
`ifdef MEM_MMIO_OUT_EN
   logic [DATA_W-1:0] mmio_out;
   logic              mmio_strobe;
`endif

   modport master (
      output addressbus, read, write, toram,
      output ld_valid, ld_data, ld_last, ld_start,
      input  fromram, cpu_enable, ld_ready, load_err, state_o
`ifdef MEM_MMIO_OUT_EN
      , input mmio_out, mmio_strobe
`endif
   );

   modport slave (
      input  addressbus, read, write, toram,
      input  ld_valid, ld_data, ld_last, ld_start,
      output fromram, cpu_enable, ld_ready, load_err, state_o
`ifdef MEM_MMIO_OUT_EN
      , output mmio_out, mmio_strobe
`endif
   );
endinterface

// File: rtl/mem_unit.sv
// ---------------------------------------------------------------------------
// mem_unit -- program/data memory for the control unit, with a streaming
// program loader that holds the CPU off while it fills the array.
//
// Optional feature macro: MEM_MMIO_OUT_EN. When defined, the top address is
// a write-only-from-CPU output register (mmio_out) with a one-cycle strobe,
// reads of that address return the register, and the loader stops one word
// earlier. When undefined, the top address is ordinary memory.
//
// Ports:
//   clk    clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset (deassertion synchronised inside)
//   bus    mem_unit_if.slave -- CPU port, loader handshake, status outputs
//
// States (state_o): IDLE=0 (CPU held, waiting for ld_start),
//                   LOAD=1 (accepting loader words), RUN=2 (CPU enabled).
// Memory contents survive reset; only control state is cleared.
// ---------------------------------------------------------------------------
module mem_unit #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 8,
   parameter int LOAD_BASE = 1
) (
   input  logic     clk,
   input  logic     rst_n,
   mem_unit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } state_t;

   localparam int                DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] TOP_ADDR  = '1;
   localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(LOAD_BASE);
`ifdef MEM_MMIO_OUT_EN
   // The top word is the MMIO register, so the loader must stop below it.
   localparam logic [ADDR_W-1:0] LOAD_LIMIT = TOP_ADDR - ADDR_W'(1);
`else
   localparam logic [ADDR_W-1:0] LOAD_LIMIT = TOP_ADDR;
`endif

   state_t            state;
   state_t            state_next;
   logic [1:0]        rst_sync;
   logic              run_ok;
   logic [ADDR_W-1:0] counter;
   logic              err_q;
   logic              ld_accept;
   logic              cpu_wr;
   logic              mem_cpu_wr;
   logic [DATA_W-1:0] mem [DEPTH];

   // Reset asserts immediately but releases two clocks later, so the FSM
   // never acts on an ld_start that races the reset deassertion.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign run_ok = rst_sync[1];

   // ld_start takes priority over a same-edge handshake: the word is dropped.
   assign ld_accept = (state == LOAD) && bus.ld_valid && !bus.ld_start;
   assign cpu_wr    = (state == RUN) && bus.write;

`ifdef MEM_MMIO_OUT_EN
   logic              mmio_hit;
   logic [DATA_W-1:0] mmio_q;
   logic              strobe_q;

   assign mmio_hit   = (bus.addressbus == TOP_ADDR);
   assign mem_cpu_wr = cpu_wr && !mmio_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mmio_q   <= '0;
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= cpu_wr && mmio_hit;
         if (cpu_wr && mmio_hit) mmio_q <= bus.toram;
      end
   end

   assign bus.mmio_out    = mmio_q;
   assign bus.mmio_strobe = strobe_q;
`else
   assign mem_cpu_wr = cpu_wr;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // ---------------- FSM: next-state logic ----------------
   // NOTE: state_next is given a default first so no path through the case
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (bus.ld_start && run_ok) state_next = LOAD;
         LOAD: begin
            if (ld_accept) begin
               if (bus.ld_last)                state_next = RUN;
               else if (counter == LOAD_LIMIT) state_next = IDLE;
            end
         end
         RUN:     if (bus.ld_start) state_next = LOAD;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.cpu_enable = 1'b0;
      bus.ld_ready   = 1'b0;
      case (state)
         LOAD:    bus.ld_ready   = 1'b1;
         RUN:     bus.cpu_enable = 1'b1;
         default: ;
      endcase
   end

   assign bus.state_o  = state;
   assign bus.load_err = err_q;

   // Load address counter: restarts on every ld_start and saturates at the
   // limit so an overflowing load never wraps onto low memory.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   counter <= BASE_ADDR;
      else if (bus.ld_start)                        counter <= BASE_ADDR;
      else if (ld_accept && counter != LOAD_LIMIT)  counter <= counter + ADDR_W'(1);
   end

   // Sticky overflow flag: a non-final word landed in the last loadable slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            err_q <= 1'b0;
      else if (bus.ld_start) err_q <= 1'b0;
      else if (ld_accept && !bus.ld_last && counter == LOAD_LIMIT)
                             err_q <= 1'b1;
   end

   // Storage array. Loader and CPU writes are exclusive by state.
   // NOTE: the array has no reset branch on purpose -- program contents must
   // survive reset, and a reset port would stop it mapping onto RAM.
   always_ff @(posedge clk) begin
      if (ld_accept)       mem[counter]        <= bus.ld_data;
      else if (mem_cpu_wr) mem[bus.addressbus] <= bus.toram;
   end

   // Combinational read: returns pre-write contents during a same-cycle write.
   always_comb begin
      bus.fromram = '0;
      if (bus.read) begin
`ifdef MEM_MMIO_OUT_EN
         if (mmio_hit) bus.fromram = mmio_q;
         else          bus.fromram = mem[bus.addressbus];
`else
         bus.fromram = mem[bus.addressbus];
`endif
      end
   end

endmodule

// File: tb/tb_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_unit -- directed bench for mem_unit. Two instances share clock and
// reset: dut8 (ADDR_W=8) for the main load/run flow, dut4 (ADDR_W=4) for the
// loader overflow case. Inputs are driven on the falling edge; combinational
// read data is sampled just after driving, registered outputs 1 time unit
// after the rising edge.
// ---------------------------------------------------------------------------
module tb_mem_unit;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

`ifdef MEM_MMIO_OUT_EN
   localparam int LIMIT4 = 14;
`else
   localparam int LIMIT4 = 15;
`endif

   mem_unit_if #(.DATA_W(16), .ADDR_W(8)) b8 ();
   mem_unit_if #(.DATA_W(16), .ADDR_W(4)) b4 ();

   mem_unit #(.DATA_W(16), .ADDR_W(8), .LOAD_BASE(1)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(b8.slave));
   mem_unit #(.DATA_W(16), .ADDR_W(4), .LOAD_BASE(1)) dut4 (
      .clk(clk), .rst_n(rst_n), .bus(b4.slave));

   typedef struct {
      logic        rd;
      logic        wr;
      logic [7:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp_data;
      string       name;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic start8();
      @(negedge clk); b8.ld_start = 1'b1;
      @(posedge clk); #1; b8.ld_start = 1'b0;
   endtask

   task automatic ld8(input logic [15:0] d, input logic last);
      @(negedge clk); b8.ld_valid = 1'b1; b8.ld_data = d; b8.ld_last = last;
      @(posedge clk); #1; b8.ld_valid = 1'b0; b8.ld_last = 1'b0;
   endtask

   task automatic wr8(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk); b8.write = 1'b1; b8.addressbus = a; b8.toram = d;
      @(posedge clk); #1; b8.write = 1'b0;
   endtask

   task automatic rd8(input string name, input logic [7:0] a, input logic [15:0] e);
      @(negedge clk); b8.read = 1'b1; b8.addressbus = a;
      #1; check(name, b8.fromram, e);
      b8.read = 1'b0;
   endtask

   task automatic ld4(input logic [15:0] d, input logic last);
      @(negedge clk); b4.ld_valid = 1'b1; b4.ld_data = d; b4.ld_last = last;
      @(posedge clk); #1; b4.ld_valid = 1'b0; b4.ld_last = 1'b0;
   endtask

   task automatic rd4(input string name, input logic [3:0] a, input logic [15:0] e);
      @(negedge clk); b4.read = 1'b1; b4.addressbus = a;
      #1; check(name, b4.fromram, e);
      b4.read = 1'b0;
   endtask

   task automatic wait_sync();
      repeat (3) @(posedge clk);
      #1;
   endtask

   vec_t vecs[$];

   initial begin
      // RUN-state read/write table, applied after the first load.
      vecs.push_back('{1'b1, 1'b0, 8'h01, 16'h0000, 16'h1111, "rd_1"});
      vecs.push_back('{1'b1, 1'b0, 8'h02, 16'h0000, 16'h2222, "rd_2"});
      vecs.push_back('{1'b1, 1'b0, 8'h03, 16'h0000, 16'h3333, "rd_3"});
      vecs.push_back('{1'b0, 1'b1, 8'h10, 16'hBEEF, 16'h0000, "wr_10_rd0"});
      vecs.push_back('{1'b1, 1'b0, 8'h10, 16'h0000, 16'hBEEF, "rd_10"});
      vecs.push_back('{1'b0, 1'b0, 8'h10, 16'h0000, 16'h0000, "rd0_10"});
      vecs.push_back('{1'b0, 1'b1, 8'h20, 16'h1234, 16'h0000, "wr_20"});
      vecs.push_back('{1'b1, 1'b1, 8'h20, 16'h5678, 16'h1234, "rdwr_20_old"});
      vecs.push_back('{1'b1, 1'b0, 8'h20, 16'h0000, 16'h5678, "rd_20_new"});
      vecs.push_back('{1'b0, 1'b1, 8'h04, 16'h4444, 16'h0000, "wr_04"});
      vecs.push_back('{1'b1, 1'b0, 8'h04, 16'h0000, 16'h4444, "rd_04"});
      vecs.push_back('{1'b1, 1'b0, 8'h01, 16'h0000, 16'h1111, "rd_1_again"});

      rst_n = 1'b1;
      b8.addressbus = '0; b8.read = 0; b8.write = 0; b8.toram = '0;
      b8.ld_valid = 0; b8.ld_data = '0; b8.ld_last = 0; b8.ld_start = 0;
      b4.addressbus = '0; b4.read = 0; b4.write = 0; b4.toram = '0;
      b4.ld_valid = 0; b4.ld_data = '0; b4.ld_last = 0; b4.ld_start = 0;

      // ---- reset ----
      #2 rst_n = 1'b0;
      #1;
      check("rst_state", b8.state_o, 2'd0);
      check("rst_cpu_en", b8.cpu_enable, 1'b0);
      check("rst_ld_ready", b8.ld_ready, 1'b0);
      check("rst_load_err", b8.load_err, 1'b0);
`ifdef MEM_MMIO_OUT_EN
      check("rst_mmio_out", b8.mmio_out, 16'h0000);
      check("rst_mmio_strobe", b8.mmio_strobe, 1'b0);
`endif
      repeat (2) @(posedge clk);

      // ld_start in the first cycle after release must be ignored.
      @(negedge clk); rst_n = 1'b1; b8.ld_start = 1'b1;
      @(posedge clk); #1; b8.ld_start = 1'b0;
      check("sync_ignores_start", b8.state_o, 2'd0);
      wait_sync();

      // ---- load three words ----
      start8();
      check("load_state", b8.state_o, 2'd1);
      check("load_ready", b8.ld_ready, 1'b1);
      check("load_cpu_en", b8.cpu_enable, 1'b0);
      ld8(16'h1111, 1'b0);
      ld8(16'h2222, 1'b0);
      check("mid_load_state", b8.state_o, 2'd1);
      ld8(16'h3333, 1'b1);
      check("run_state", b8.state_o, 2'd2);
      check("run_cpu_en", b8.cpu_enable, 1'b1);
      check("run_ld_ready", b8.ld_ready, 1'b0);

      // ---- RUN table ----
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         b8.read = vecs[i].rd; b8.write = vecs[i].wr;
         b8.addressbus = vecs[i].addr; b8.toram = vecs[i].wdata;
         #1; check(vecs[i].name, b8.fromram, vecs[i].exp_data);
      end
      @(negedge clk); b8.read = 0; b8.write = 0;

      // ld_valid ignored in RUN
      @(negedge clk); b8.ld_valid = 1'b1; b8.ld_data = 16'h9999;
      @(posedge clk); #1; b8.ld_valid = 1'b0;
      check("run_ignores_ld", b8.state_o, 2'd2);
      rd8("run_ld_no_write", 8'h04, 16'h4444);

      // ---- ld_start in RUN during a CPU write ----
      @(negedge clk);
      b8.ld_start = 1'b1; b8.write = 1'b1; b8.addressbus = 8'h40; b8.toram = 16'h7777;
      @(posedge clk); #1; b8.ld_start = 1'b0; b8.write = 1'b0;
      check("restart_state", b8.state_o, 2'd1);
      check("restart_cpu_en", b8.cpu_enable, 1'b0);
      rd8("restart_write_landed", 8'h40, 16'h7777);

      // CPU write outside RUN is ignored
      wr8(8'h03, 16'hDEAD);
      rd8("load_write_ignored", 8'h03, 16'h3333);

      // ---- ld_start in LOAD discards same-edge handshake ----
      ld8(16'h6161, 1'b0);
      @(negedge clk);
      b8.ld_start = 1'b1; b8.ld_valid = 1'b1; b8.ld_data = 16'hAAAA;
      @(posedge clk); #1; b8.ld_start = 1'b0; b8.ld_valid = 1'b0;
      check("reload_state", b8.state_o, 2'd1);
      ld8(16'h5151, 1'b1);
      check("reload_run", b8.state_o, 2'd2);
      rd8("reload_addr1", 8'h01, 16'h5151);
      rd8("reload_discarded", 8'h02, 16'h2222);

      // ---- reset mid-LOAD ----
      start8();
      ld8(16'h7171, 1'b0);
      @(negedge clk); #2 rst_n = 1'b0;
      #1;
      check("async_rst_state", b8.state_o, 2'd0);
      check("async_rst_ready", b8.ld_ready, 1'b0);
      check("async_rst_cpu_en", b8.cpu_enable, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      wait_sync();
      check("post_rst_state", b8.state_o, 2'd0);
      rd8("retain_1", 8'h01, 16'h7171);
      rd8("retain_2", 8'h02, 16'h2222);
      rd8("retain_10", 8'h10, 16'hBEEF);
      rd8("retain_40", 8'h40, 16'h7777);

      // ---- top address ----
      start8();
      ld8(16'h0101, 1'b1);
      check("top_run", b8.state_o, 2'd2);
`ifdef MEM_MMIO_OUT_EN
      wr8(8'hFF, 16'h00AB);
      check("mmio_out", b8.mmio_out, 16'h00AB);
      check("mmio_strobe_hi", b8.mmio_strobe, 1'b1);
      @(posedge clk); #1;
      check("mmio_strobe_lo", b8.mmio_strobe, 1'b0);
      rd8("mmio_read", 8'hFF, 16'h00AB);
      check("mmio_mem_untouched", dut8.mem[255] === 16'h00AB, 1'b0);
`else
      wr8(8'hFF, 16'hCAFE);
      rd8("top_is_memory", 8'hFF, 16'hCAFE);
`endif

      // ---- overflow on ADDR_W=4 ----
      @(negedge clk); b4.ld_start = 1'b1;
      @(posedge clk); #1; b4.ld_start = 1'b0;
      check("ovf_load_state", b4.state_o, 2'd1);
      for (int i = 0; i < LIMIT4; i++) begin
         ld4(16'h0A00 + 16'(i), 1'b0);
         if (i == LIMIT4 - 2) begin
            check("ovf_before_err", b4.load_err, 1'b0);
            check("ovf_before_state", b4.state_o, 2'd1);
         end
      end
      check("ovf_err", b4.load_err, 1'b1);
      check("ovf_state", b4.state_o, 2'd0);
      check("ovf_ready", b4.ld_ready, 1'b0);
      @(negedge clk); b4.ld_start = 1'b1;
      @(posedge clk); #1; b4.ld_start = 1'b0;
      check("ovf_err_cleared", b4.load_err, 1'b0);
      check("ovf_reload_state", b4.state_o, 2'd1);
      rd4("ovf_last_word", 4'(LIMIT4), 16'h0A00 + 16'(LIMIT4 - 1));
      rd4("ovf_first_word", 4'd1, 16'h0A00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
